// File: rtl/ultrasonic_pkg.sv
// Shared FSM encoding and default parameter values for the ultrasonic scanner.
package ultrasonic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT_RISE,
        ST_MEASURE,
        ST_HOLD
    } state_t;

    localparam int DEF_NUM_CH        = 4;
    localparam int DEF_CM_W          = 16;
    localparam int DEF_TRIG_CYCLES   = 500;
    localparam int DEF_CYCLES_PER_CM = 2900;
    localparam int DEF_PERIOD_CYCLES = 5000000;
    localparam int DEF_MAX_CM        = 400;

endpackage

// File: rtl/echo_sync.sv
// Two-flop synchronizer for one echo line with rise/fall detection on the
// synchronized level.
module echo_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic sync_p0;
    logic sync_p1;
    logic sync_p2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
        end else begin
            sync_p0 <= async_in;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    // sync_p2 only remembers the previous synchronized level for edge detect
    assign rise = sync_p1 & ~sync_p2;
    assign fall = ~sync_p1 & sync_p2;

endmodule

// File: rtl/ultrasonic_scanner.sv
// Round-robin ultrasonic ranger: triggers one sensor per slot, times its echo
// in centimetres and latches a per-channel distance and timeout flag.
module ultrasonic_scanner
    import ultrasonic_pkg::*;
#(
    parameter int NUM_CH        = DEF_NUM_CH,
    parameter int CM_W          = DEF_CM_W,
    parameter int TRIG_CYCLES   = DEF_TRIG_CYCLES,
    parameter int CYCLES_PER_CM = DEF_CYCLES_PER_CM,
    parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES,
    parameter int MAX_CM        = DEF_MAX_CM
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NUM_CH-1:0]      echo,
    output logic [NUM_CH-1:0]      trigger,
    output logic [NUM_CH*CM_W-1:0] dist_cm,
    output logic [NUM_CH-1:0]      timeout,
    output logic                   sample_valid,
    output logic [2:0]             sample_ch,
    output logic                   busy
);

    localparam int SLOT_W = $clog2(PERIOD_CYCLES);
    localparam int SUB_W  = $clog2(CYCLES_PER_CM + 1);

    // The slot spans PERIOD_CYCLES including the single IDLE cycle that closes
    // it, so back-to-back triggers land exactly PERIOD_CYCLES apart.
    localparam logic [SLOT_W-1:0] TRIG_END = SLOT_W'(TRIG_CYCLES - 1);
    localparam logic [SLOT_W-1:0] SLOT_TMO = SLOT_W'(PERIOD_CYCLES - 3);
    localparam logic [SLOT_W-1:0] SLOT_END = SLOT_W'(PERIOD_CYCLES - 2);
    localparam logic [SUB_W-1:0]  SUB_WRAP = SUB_W'(CYCLES_PER_CM - 1);
    localparam logic [CM_W-1:0]   CM_MAX   = CM_W'(MAX_CM);
    localparam logic [2:0]        CH_LAST  = 3'(NUM_CH - 1);

    function automatic logic [CM_W-1:0] sat_inc(input logic [CM_W-1:0] v);
        return (v >= CM_MAX) ? CM_MAX : v + CM_W'(1);
    endfunction

    state_t            state;
    logic [2:0]        ch;
    logic [SLOT_W-1:0] slot_cnt;
    logic [SUB_W-1:0]  sub_cnt;
    logic [CM_W-1:0]   cm;

    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] fall;
    logic [NUM_CH-1:0] ch_onehot;
    logic              sel_rise;
    logic              sel_fall;

    logic [SUB_W-1:0]  sub_next;
    logic [CM_W-1:0]   cm_next;
    logic              result_now;
    logic [CM_W-1:0]   result_cm;
    logic              result_tmo;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_sync
        echo_sync u_sync (
            .clk      (clk),
            .reset    (reset),
            .async_in (echo[i]),
            .rise     (rise[i]),
            .fall     (fall[i])
        );
    end

    always_comb begin
        ch_onehot = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_onehot[i] = (ch == 3'(i));
        end
    end

    assign sel_rise = |(rise & ch_onehot);
    assign sel_fall = |(fall & ch_onehot);

    // Saturation and slot end outrank a fall seen in the same cycle; the fall
    // cycle itself still counts toward the distance.
    always_comb begin
        sub_next   = (sub_cnt == SUB_WRAP) ? '0 : sub_cnt + SUB_W'(1);
        cm_next    = (sub_cnt == SUB_WRAP) ? sat_inc(cm) : cm;
        result_now = 1'b0;
        result_cm  = CM_MAX;
        result_tmo = 1'b1;
        case (state)
            ST_WAIT_RISE: result_now = (slot_cnt == SLOT_TMO);
            ST_MEASURE: begin
                if (cm_next == CM_MAX || slot_cnt == SLOT_TMO) begin
                    result_now = 1'b1;
                end else if (sel_fall) begin
                    result_now = 1'b1;
                    result_cm  = cm_next;
                    result_tmo = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            ch           <= '0;
            slot_cnt     <= '0;
            sub_cnt      <= '0;
            cm           <= '0;
            trigger      <= '0;
            dist_cm      <= '0;
            timeout      <= '0;
            sample_valid <= 1'b0;
            sample_ch    <= '0;
            busy         <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (state != ST_IDLE) begin
                slot_cnt <= slot_cnt + SLOT_W'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state    <= ST_TRIG;
                        trigger  <= ch_onehot;
                        busy     <= 1'b1;
                        slot_cnt <= '0;
                    end
                end
                ST_TRIG: begin
                    if (slot_cnt == TRIG_END) begin
                        state   <= ST_WAIT_RISE;
                        trigger <= '0;
                    end
                end
                ST_WAIT_RISE: begin
                    if (!result_now && sel_rise) begin
                        cm      <= '0;
                        sub_cnt <= '0;
                        state   <= ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (!result_now) begin
                        cm      <= cm_next;
                        sub_cnt <= sub_next;
                    end
                end
                ST_HOLD: begin
                    if (slot_cnt >= SLOT_END) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        ch    <= (ch == CH_LAST) ? 3'd0 : ch + 3'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (result_now) begin
                state        <= ST_HOLD;
                sample_valid <= 1'b1;
                sample_ch    <= ch;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (ch_onehot[i]) begin
                        dist_cm[i*CM_W +: CM_W] <= result_cm;
                        timeout[i]              <= result_tmo;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ultrasonic_scanner.sv
// Directed bench for ultrasonic_scanner with shortened timing parameters:
// 5-cycle trigger, 4 cycles per cm, 400-cycle slot, 20 cm ceiling.
module tb_ultrasonic_scanner;

    localparam int NUM_CH = 4;
    localparam int CM_W   = 16;
    localparam int TRIG   = 5;
    localparam int CPC    = 4;
    localparam int PERIOD = 400;
    localparam int MAXCM  = 20;

    logic                   clk;
    logic                   reset;
    logic                   enable;
    logic [NUM_CH-1:0]      echo;
    logic [NUM_CH-1:0]      trigger;
    logic [NUM_CH*CM_W-1:0] dist_cm;
    logic [NUM_CH-1:0]      timeout;
    logic                   sample_valid;
    logic [2:0]             sample_ch;
    logic                   busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int sv_count = 0;
    int t0, t1, t2, t3, n;

    ultrasonic_scanner #(
        .NUM_CH        (NUM_CH),
        .CM_W          (CM_W),
        .TRIG_CYCLES   (TRIG),
        .CYCLES_PER_CM (CPC),
        .PERIOD_CYCLES (PERIOD),
        .MAX_CM        (MAXCM)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .echo         (echo),
        .trigger      (trigger),
        .dist_cm      (dist_cm),
        .timeout      (timeout),
        .sample_valid (sample_valid),
        .sample_ch    (sample_ch),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sample_valid === 1'b1) sv_count <= sv_count + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_trigger(input logic [NUM_CH-1:0] want, input string tag);
        int k = 0;
        while (trigger !== want && k < 2000) begin
            step();
            k++;
        end
        check(tag, 64'(trigger), 64'(want));
    endtask

    task automatic wait_sv(input string tag);
        int k = 0;
        while (sample_valid !== 1'b1 && k < 600) begin
            step();
            k++;
        end
        check(tag, 64'(sample_valid), 64'd1);
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        echo   = '0;
        repeat (3) step();
        check("rst_trigger", 64'(trigger), 64'd0);
        check("rst_dist", dist_cm, 64'd0);
        check("rst_timeout", 64'(timeout), 64'd0);
        check("rst_sv", 64'(sample_valid), 64'd0);
        check("rst_sample_ch", 64'(sample_ch), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);

        reset = 1'b0;
        step();
        check("idle_no_enable_busy", 64'(busy), 64'd0);

        // Channel 0: trigger width, foreign echo on ch3, then a 40-cycle echo -> 10 cm
        enable = 1'b1;
        step();
        check("ch0_trigger_start", 64'(trigger), 64'b0001);
        check("ch0_busy", 64'(busy), 64'd1);
        t0 = cyc;
        n = 0;
        while (trigger === 4'b0001 && n < 100) begin
            step();
            n++;
        end
        check("ch0_trigger_len", 64'(n), 64'(TRIG));

        echo[3] = 1'b1;
        repeat (10) step();
        echo[3] = 1'b0;
        repeat (6) step();
        check("ch3_ignored_sv", 64'(sv_count), 64'd0);
        check("ch3_ignored_dist", dist_cm, 64'd0);

        echo[0] = 1'b1;
        repeat (40) step();
        echo[0] = 1'b0;
        wait_sv("ch0_sv_seen");
        check("ch0_sample_ch", 64'(sample_ch), 64'd0);
        check("ch0_dist", 64'(dist_cm[15:0]), 64'd10);
        check("ch0_timeout", 64'(timeout[0]), 64'd0);

        // Channel 1: echo held high well past 20 cm -> saturation then HOLD
        wait_trigger(4'b0010, "ch1_trigger_start");
        t1 = cyc;
        check("ch1_period", 64'(t1 - t0), 64'(PERIOD));
        check("ch0_one_sv", 64'(sv_count), 64'd1);
        repeat (6) step();
        echo[1] = 1'b1;
        wait_sv("ch1_sv_seen");
        check("ch1_sample_ch", 64'(sample_ch), 64'd1);
        check("ch1_dist_sat", 64'(dist_cm[31:16]), 64'(MAXCM));
        check("ch1_timeout", 64'(timeout[1]), 64'd1);
        repeat (10) step();
        check("ch1_hold_busy", 64'(busy), 64'd1);
        check("ch1_hold_trigger", 64'(trigger), 64'd0);
        echo[2] = 1'b1;
        repeat (50) step();
        echo[1] = 1'b0;

        // Channel 2: echo already high on entry never rises -> slot timeout
        wait_trigger(4'b0100, "ch2_trigger_start");
        t2 = cyc;
        check("ch2_period", 64'(t2 - t1), 64'(PERIOD));
        check("ch1_one_sv", 64'(sv_count), 64'd2);
        wait_sv("ch2_sv_seen");
        check("ch2_sample_ch", 64'(sample_ch), 64'd2);
        check("ch2_dist", 64'(dist_cm[47:32]), 64'(MAXCM));
        check("ch2_timeout", 64'(timeout[2]), 64'd1);
        check("all_dist_after_ch2", dist_cm, 64'h0000_0014_0014_000A);
        echo[2] = 1'b0;

        // Channel 3: enable dropped mid-slot, slot still completes -> 3 cm
        wait_trigger(4'b1000, "ch3_trigger_start");
        t3 = cyc;
        check("ch3_period", 64'(t3 - t2), 64'(PERIOD));
        check("ch2_one_sv", 64'(sv_count), 64'd3);
        enable = 1'b0;
        repeat (8) step();
        echo[3] = 1'b1;
        repeat (12) step();
        echo[3] = 1'b0;
        wait_sv("ch3_sv_seen");
        check("ch3_sample_ch", 64'(sample_ch), 64'd3);
        check("all_dist_after_ch3", dist_cm, 64'h0003_0014_0014_000A);
        check("all_timeout_after_ch3", 64'(timeout), 64'b0110);
        n = 0;
        while (busy === 1'b1 && n < 500) begin
            step();
            n++;
        end
        check("stopped_busy", 64'(busy), 64'd0);
        repeat (20) step();
        check("stopped_trigger", 64'(trigger), 64'd0);
        check("stopped_busy_still", 64'(busy), 64'd0);
        check("ch3_one_sv", 64'(sv_count), 64'd4);

        // Re-enable: channel index wrapped to 0; 8-cycle echo -> 2 cm
        enable = 1'b1;
        step();
        check("wrap_trigger_ch0", 64'(trigger), 64'b0001);
        repeat (6) step();
        echo[0] = 1'b1;
        repeat (8) step();
        echo[0] = 1'b0;
        wait_sv("ch0b_sv_seen");
        check("ch0b_dist", 64'(dist_cm[15:0]), 64'd2);

        // Reset during channel 1 MEASURE discards the measurement
        wait_trigger(4'b0010, "ch1b_trigger_start");
        repeat (6) step();
        echo[1] = 1'b1;
        repeat (20) step();
        reset   = 1'b1;
        echo[1] = 1'b0;
        step();
        check("mid_rst_trigger", 64'(trigger), 64'd0);
        check("mid_rst_dist", dist_cm, 64'd0);
        check("mid_rst_timeout", 64'(timeout), 64'd0);
        check("mid_rst_sv", 64'(sample_valid), 64'd0);
        check("mid_rst_sample_ch", 64'(sample_ch), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        step();
        check("restart_trigger_ch0", 64'(trigger), 64'b0001);
        step();
        check("total_sv_count", 64'(sv_count), 64'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
